div_unit: RTL

Multi-cycle 32-bit integer divider for the EX stage of the MIPS core, executing DIV/DIVU beside the single-cycle ALU. It holds the pipeline with a stall output while iterating. It delivers quotient and remainder to the HI/LO write path, which later MFLO/MFHI reads through the ALU. Radix-2 restoring division on magnitudes, with sign fix-up for signed operations.

---
 rtl/div_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Divides magnitudes for 32 cycles, then fixes up signs and publishes quotient/remainder.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        stall,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        dvd_neg_q, dvd_neg_d;
  logic        dvs_neg_q, dvs_neg_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rmd_q, rmd_d;
  logic        accept;
  logic [32:0] shifted;
  logic [33:0] trial;

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && start && !annul;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      sgn_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      rem_q     <= 32'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      quo_q     <= 32'd0;
      rmd_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      dvd_neg_q <= dvd_neg_d;
      dvs_neg_q <= dvs_neg_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = RUN;
        RUN:     if (cnt_q == 6'd31) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = accept ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom.
  always_comb begin
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    dvd_neg_d = dvd_neg_q;
    dvs_neg_d = dvs_neg_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    shifted   = {rem_q, dvd_q[31]};
    trial     = {1'b0, shifted} - {2'b00, dvs_q};
    if (accept) begin
      sgn_d     = is_signed;
      dvd_neg_d = dividend[31];
      dvs_neg_d = divisor[31];
      dvd_d     = (is_signed && dividend[31]) ? (~dividend + 32'd1) : dividend;
      dvs_d     = (is_signed && divisor[31]) ? (~divisor + 32'd1) : divisor;
      rem_d     = 32'd0;
      cnt_d     = 6'd0;
    end else if (!annul && (state_q == RUN)) begin
      rem_d = trial[33] ? shifted[31:0] : trial[31:0];
      dvd_d = {dvd_q[30:0], ~trial[33]};
      cnt_d = cnt_q + 6'd1;
    end else if (!annul && (state_q == FIX)) begin
      quo_d = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? (~dvd_q + 32'd1) : dvd_q;
      rmd_d = (sgn_q && dvd_neg_q) ? (~rem_q + 32'd1) : rem_q;
    end
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    if (resetn) begin
      stall = accept || (state_q == RUN) || (state_q == FIX);
      done  = (state_q == DONE) && !annul;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule
